ones_count_expander: RTL and testbench

//   Inverse of the 3-input ones-counter: accepts a binary ones-count and
//   re-expands it into a serial FRAME-bit thermometer stream (count ones, then

---
 rtl/ones_count_expander.sv | 77 +++++++
 tb/tb_ones_count_expander.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ones_count_expander.sv
// ones_count_expander: expands a binary ones-count into a serial FRAME-bit thermometer stream.
// Optional frame parity output enabled by defining ONES_EXP_PARITY_EN.
module ones_count_expander #(
    parameter int CNT_W = 2,
    parameter int FRAME = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             err_ovf,
    output logic             out_par
);
    localparam int IW = $clog2(FRAME) + 1;
    localparam logic [IW-1:0] FRAME_I = IW'(FRAME);
    localparam logic [IW-1:0] LAST_I = IW'(FRAME - 1);
    localparam logic [CNT_W:0] FRAME_C = (CNT_W + 1)'(FRAME);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t state, state_nx;
    logic [IW-1:0] idx, cnt_q, sat;
    logic accept, fire, ovf;

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == EMIT);
        out_bit   = out_valid && (idx < cnt_q);
        out_last  = out_valid && (idx == LAST_I);
        accept    = in_valid && in_ready;
        fire      = out_valid && out_ready;
        ovf       = {1'b0, in_count} > FRAME_C;
        // saturated count always fits idx width since it never exceeds FRAME
        sat       = ovf ? FRAME_I : IW'(in_count);
        state_nx  = state;
        if (accept)
            state_nx = EMIT;
        else if (fire && out_last)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt_q   <= '0;
            err_ovf <= 1'b0;
        end else begin
            state   <= state_nx;
            err_ovf <= accept && ovf;
            if (accept) begin
                cnt_q <= sat;
                idx   <= '0;
            end else if (fire && !out_last) begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef ONES_EXP_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_par <= 1'b0;
        else if (accept)
            out_par <= ^sat;
        else if (fire && out_last)
            out_par <= 1'b0;
    end
`else
    assign out_par = 1'b0;
`endif
endmodule

// File: tb/tb_ones_count_expander.sv
// tb_ones_count_expander: directed stimulus with a queue-based frame model checked every cycle.
module tb_ones_count_expander;
    localparam int FA = 3;
    localparam int FB = 4;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready, out_bit, out_last, err_ovf, out_par;
    logic [1:0] in_count;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_bit, b_out_last, b_err_ovf, b_out_par;
    logic [2:0] b_in_count;

    int checks = 0;
    int passed = 0;
    bit q[$];
    bit seen[$];
    bit err_exp = 1'b0;
    bit par_exp = 1'b0;

    always #5 clk = ~clk;

    ones_count_expander #(.CNT_W(2), .FRAME(FA)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_count(in_count), .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_last(out_last), .err_ovf(err_ovf), .out_par(out_par)
    );

    ones_count_expander #(.CNT_W(3), .FRAME(FB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_count(b_in_count), .out_valid(b_out_valid), .out_ready(1'b1),
        .out_bit(b_out_bit), .out_last(b_out_last), .err_ovf(b_err_ovf), .out_par(b_out_par)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: an accepted count becomes a queue of FRAME expected bits; non-empty queue means EMIT.
    always @(negedge clk) begin
        int sat;
        if (!rst_n) begin
            q.delete();
            err_exp = 1'b0;
            par_exp = 1'b0;
        end
        chk("in_ready", in_ready, q.size() == 0);
        chk("out_valid", out_valid, q.size() != 0);
        chk("out_bit", out_bit, q.size() != 0 ? q[0] : 1'b0);
        chk("out_last", out_last, q.size() == 1);
        chk("err_ovf", err_ovf, err_exp);
        chk("out_par", out_par, par_exp);
        if (rst_n) begin
            err_exp = 1'b0;
            if (q.size() != 0 && out_ready) begin
                seen.push_back(q.pop_front());
                if (q.size() == 0) par_exp = 1'b0;
            end else if (q.size() == 0 && in_valid) begin
                sat = (int'(in_count) > FA) ? FA : int'(in_count);
                for (int i = 0; i < FA; i++) q.push_back(i < sat);
                err_exp = int'(in_count) > FA;
`ifdef ONES_EXP_PARITY_EN
                par_exp = sat[0] ^ sat[1];
`else
                par_exp = 1'b0;
`endif
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", n < 50, 1);
    endtask

    task automatic send(input logic [1:0] c);
        wait_idle();
        in_count = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic int packed_seen();
        int v = 0;
        foreach (seen[i]) v = (v << 1) | int'(seen[i]);
        return v;
    endfunction

    task automatic frame_chk(input string name, input int exp);
        wait_idle();
        chk(name, packed_seen(), exp);
        chk({name, "_len"}, seen.size(), FA);
        seen.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_count = '0;
        out_ready = 1'b1;
        b_in_valid = 1'b0;
        b_in_count = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err_ovf, 0);
        chk("rst_par", out_par, 0);

        // count=2 with an in_count change mid-frame that must be ignored
        send(2'd2);
        chk("t1_first_valid", out_valid, 1);
        in_valid = 1'b1;
        in_count = 2'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        frame_chk("t1_frame", 3'b110);

        send(2'd0);
        frame_chk("t2_zero", 3'b000);
        send(2'd3);
`ifdef ONES_EXP_PARITY_EN
        chk("t6_par3", out_par, 0);
`endif
        frame_chk("t2_full", 3'b111);

        // backpressure on bit 0
        out_ready = 1'b0;
        send(2'd1);
`ifdef ONES_EXP_PARITY_EN
        chk("t6_par1", out_par, 1);
`else
        chk("t6_par_off", out_par, 0);
`endif
        repeat (3) begin
            chk("t4_hold_bit", out_bit, 1);
            chk("t4_hold_idx", dut_a.idx, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        frame_chk("t4_frame", 3'b100);

        // abort mid-frame with reset
        send(2'd3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_abort_valid", out_valid, 0);
        chk("t5_abort_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen.delete();
        send(2'd2);
        frame_chk("t5_after", 3'b110);

        // wider instance: count 6 saturates to FRAME=4
        b_in_count = 3'd6;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        for (int i = 0; i < FB; i++) begin
            chk("t3_valid", b_out_valid, 1);
            chk("t3_bit", b_out_bit, 1);
            chk("t3_last", b_out_last, i == FB - 1);
            chk("t3_err", b_err_ovf, i == 0);
            @(posedge clk);
            #1;
        end
        chk("t3_done_valid", b_out_valid, 0);
        chk("t3_done_ready", b_in_ready, 1);
        chk("t3_done_err", b_err_ovf, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
